repairmb_partner: RTL and testbench

REPAIRMB_PARTNER -- requirements
Module: repairmb_partner

---
 rtl/repairmb_partner.sv | 153 +++++++++++++++
 tb/tb_repairmb_partner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/repairmb_partner.sv
// REPAIRMB partner-side handshake: answers start/apply_degrade/end requests over the
// sideband, applies the requested RX lane map, and flags TRAINERROR on stalls.
module repairmb_partner #(
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int CNT_W          = 20
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             MBINIT_REVERSALMB_end,
  input  logic [3:0]       i_RX_SbMessage,
  input  logic             i_msg_valid,
  input  logic [2:0]       i_rx_msg_info,
  input  logic             i_Busy_SideBand,
  input  logic             i_falling_edge_busy,
  output logic [3:0]       o_TX_SbMessage,
  output logic             o_ValidOutDatat_REPAIRMB_Partner,
  output logic [1:0]       o_Functional_Lanes_Partner,
  output logic             o_MBINIT_REPAIRMB_Partner_end,
  output logic             o_repairmb_error
);

  localparam logic [3:0] START_REQ    = 4'b0001;
  localparam logic [3:0] START_RESP_C = 4'b0010;
  localparam logic [3:0] END_REQ      = 4'b0011;
  localparam logic [3:0] END_RESP_C   = 4'b0100;
  localparam logic [3:0] DEGRADE_REQ  = 4'b0101;
  localparam logic [3:0] DEGRADE_RESP_C = 4'b0110;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    WAIT_START,
    CHK_BUSY_START,
    START_RESP,
    WAIT_REQ,
    CHK_BUSY_DEGRADE,
    DEGRADE_RESP,
    CHK_BUSY_END,
    END_RESP,
    DONE,
    ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       tx_q, tx_d;
  logic             vld_q, vld_d;
  logic [1:0]       lanes_q, lanes_d;
  logic             end_q, end_d;
  logic             err_q, err_d;

  logic             parked;
  logic             timeout;
  logic             unused_info_bit;

  assign unused_info_bit = i_rx_msg_info[2];

  // Counting is meaningless while parked in IDLE/DONE/ERROR.
  assign parked  = (state_q == IDLE) || (state_q == DONE) || (state_q == ERROR);
  assign timeout = !parked && (cnt_q >= TO_LAST);

  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    if (!MBINIT_REVERSALMB_end) begin
      state_d = IDLE;
    end else if (timeout) begin
      state_d = ERROR;
    end else begin
      case (state_q)
        IDLE:           state_d = WAIT_START;
        WAIT_START: begin
          if (i_msg_valid && (i_RX_SbMessage == START_REQ)) state_d = CHK_BUSY_START;
        end
        CHK_BUSY_START: if (!i_Busy_SideBand) state_d = START_RESP;
        START_RESP:     if (i_falling_edge_busy) state_d = WAIT_REQ;
        WAIT_REQ: begin
          if (i_msg_valid && (i_RX_SbMessage == DEGRADE_REQ)) begin
            if (i_rx_msg_info[1:0] != 2'b00) begin
              lanes_d = i_rx_msg_info[1:0];
              state_d = CHK_BUSY_DEGRADE;
            end else begin
              state_d = ERROR;
            end
          end else if (i_msg_valid && (i_RX_SbMessage == END_REQ)) begin
            state_d = CHK_BUSY_END;
          end
        end
        CHK_BUSY_DEGRADE: if (!i_Busy_SideBand) state_d = DEGRADE_RESP;
        DEGRADE_RESP:     if (i_falling_edge_busy) state_d = WAIT_REQ;
        CHK_BUSY_END:     if (!i_Busy_SideBand) state_d = END_RESP;
        END_RESP:         if (i_falling_edge_busy) state_d = DONE;
        DONE:             state_d = DONE;
        ERROR:            state_d = ERROR;
        default:          state_d = IDLE;
      endcase
    end
    if (state_d == IDLE) lanes_d = 2'b11;
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || parked) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    vld_d = 1'b0;
    tx_d  = 4'b0000;
    if (state_d != state_q) begin
      case (state_d)
        START_RESP:   begin vld_d = 1'b1; tx_d = START_RESP_C;   end
        DEGRADE_RESP: begin vld_d = 1'b1; tx_d = DEGRADE_RESP_C; end
        END_RESP:     begin vld_d = 1'b1; tx_d = END_RESP_C;     end
        default:      begin vld_d = 1'b0; tx_d = 4'b0000;        end
      endcase
    end
    end_d = (state_d == DONE);
    err_d = (state_d == ERROR);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= 4'b0000;
      vld_q   <= 1'b0;
      lanes_q <= 2'b11;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      vld_q   <= vld_d;
      lanes_q <= lanes_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  assign o_TX_SbMessage                   = tx_q;
  assign o_ValidOutDatat_REPAIRMB_Partner = vld_q;
  assign o_Functional_Lanes_Partner       = lanes_q;
  assign o_MBINIT_REPAIRMB_Partner_end    = end_q;
  assign o_repairmb_error                 = err_q;

endmodule

// File: tb/tb_repairmb_partner.sv
// Directed bench for repairmb_partner: vector table for the main handshakes plus
// hand-written busy-stall, timeout and asynchronous-reset sequences.
module tb_repairmb_partner;

  logic       CLK;
  logic       rst_n;
  logic       en;
  logic [3:0] rx_msg;
  logic       mv;
  logic [2:0] info;
  logic       busy;
  logic       feb;
  logic [3:0] tx;
  logic       vld;
  logic [1:0] lanes;
  logic       done;
  logic       err;

  int n_chk;
  int n_fail;

  repairmb_partner #(.TIMEOUT_CYCLES(16), .CNT_W(20)) dut (
    .CLK                              (CLK),
    .rst_n                            (rst_n),
    .MBINIT_REVERSALMB_end            (en),
    .i_RX_SbMessage                   (rx_msg),
    .i_msg_valid                      (mv),
    .i_rx_msg_info                    (info),
    .i_Busy_SideBand                  (busy),
    .i_falling_edge_busy              (feb),
    .o_TX_SbMessage                   (tx),
    .o_ValidOutDatat_REPAIRMB_Partner (vld),
    .o_Functional_Lanes_Partner       (lanes),
    .o_MBINIT_REPAIRMB_Partner_end    (done),
    .o_repairmb_error                 (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       en;
    logic       mv;
    logic [3:0] msg;
    logic [2:0] info;
    logic       busy;
    logic       feb;
    logic       ev;
    logic [3:0] etx;
    logic [1:0] el;
    logic       eend;
    logic       eerr;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic a_en, input logic a_mv, input logic [3:0] a_msg,
                     input logic [2:0] a_info, input logic a_busy, input logic a_feb,
                     input logic e_v, input logic [3:0] e_tx, input logic [1:0] e_l,
                     input logic e_end, input logic e_err);
    vec_t v;
    v.en = a_en; v.mv = a_mv; v.msg = a_msg; v.info = a_info; v.busy = a_busy; v.feb = a_feb;
    v.ev = e_v; v.etx = e_tx; v.el = e_l; v.eend = e_end; v.eerr = e_err;
    vt.push_back(v);
  endtask

  task automatic drive(input logic a_en, input logic a_mv, input logic [3:0] a_msg,
                       input logic [2:0] a_info, input logic a_busy, input logic a_feb);
    en = a_en; mv = a_mv; rx_msg = a_msg; info = a_info; busy = a_busy; feb = a_feb;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic e_v, input logic [3:0] e_tx,
                     input logic [1:0] e_l, input logic e_end, input logic e_err);
    n_chk++;
    if (vld !== e_v || tx !== e_tx || lanes !== e_l || done !== e_end || err !== e_err) begin
      n_fail++;
      $display("FAIL %s: got vld=%b tx=%b lanes=%b end=%b err=%b, required vld=%b tx=%b lanes=%b end=%b err=%b",
               nm, vld, tx, lanes, done, err, e_v, e_tx, e_l, e_end, e_err);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b0);

    //  en mv  msg      info    bsy  feb | vld tx       lanes end err
    // Full handshake: start, degrade(01), end, done held, enable low.
    add(1, 0, 4'b0000, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    add(1, 1, 4'b0001, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 0,  1, 4'b0010, 2'b11, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 1,  0, 4'b0000, 2'b11, 0, 0);
    add(1, 1, 4'b0101, 3'b001, 0, 0,  0, 4'b0000, 2'b01, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 0,  1, 4'b0110, 2'b01, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 1,  0, 4'b0000, 2'b01, 0, 0);
    add(1, 1, 4'b0011, 3'b000, 0, 0,  0, 4'b0000, 2'b01, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 0,  1, 4'b0100, 2'b01, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 1,  0, 4'b0000, 2'b01, 1, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 0,  0, 4'b0000, 2'b01, 1, 0);
    add(0, 0, 4'b0000, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    // start_req seen in IDLE is dropped.
    add(1, 1, 4'b0001, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    // Two degrades (10 then 11), stray start_req in WAIT_REQ ignored.
    add(1, 1, 4'b0001, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 0,  1, 4'b0010, 2'b11, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 1,  0, 4'b0000, 2'b11, 0, 0);
    add(1, 1, 4'b0101, 3'b010, 0, 0,  0, 4'b0000, 2'b10, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 0,  1, 4'b0110, 2'b10, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 1,  0, 4'b0000, 2'b10, 0, 0);
    add(1, 1, 4'b0001, 3'b000, 0, 0,  0, 4'b0000, 2'b10, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 0,  0, 4'b0000, 2'b10, 0, 0);
    add(1, 1, 4'b0101, 3'b011, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 0,  1, 4'b0110, 2'b11, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 1,  0, 4'b0000, 2'b11, 0, 0);
    // Degrade with empty lane map -> ERROR held until enable low.
    add(1, 1, 4'b0101, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 1);
    add(1, 0, 4'b0000, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 1);
    add(0, 0, 4'b0000, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    // WAIT_START ignores non-start codes.
    add(1, 0, 4'b0000, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    add(1, 1, 4'b0011, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    add(1, 1, 4'b0101, 3'b001, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    add(1, 0, 4'b0000, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    add(0, 0, 4'b0000, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    // Enable low wins over a ready CHK_BUSY_START.
    add(1, 0, 4'b0000, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    add(1, 1, 4'b0001, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    add(0, 0, 4'b0000, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);
    add(0, 0, 4'b0000, 3'b000, 0, 0,  0, 4'b0000, 2'b11, 0, 0);

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", 0, 4'b0000, 2'b11, 0, 0);
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", 0, 4'b0000, 2'b11, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].en, vt[i].mv, vt[i].msg, vt[i].info, vt[i].busy, vt[i].feb);
      step();
      chk($sformatf("vec[%0d]", i), vt[i].ev, vt[i].etx, vt[i].el, vt[i].eend, vt[i].eerr);
    end

    // Busy held for 10 cycles after start_req: no pulse until busy drops.
    drive(1, 0, 4'b0000, 3'b000, 0, 0); step();
    drive(1, 1, 4'b0001, 3'b000, 1, 0); step();
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 4'b0000, 3'b000, 1, 0); step();
      chk($sformatf("busy_hold[%0d]", k), 0, 4'b0000, 2'b11, 0, 0);
    end
    drive(1, 0, 4'b0000, 3'b000, 0, 0); step();
    chk("busy_release_pulse", 1, 4'b0010, 2'b11, 0, 0);
    step();
    chk("busy_single_pulse", 0, 4'b0000, 2'b11, 0, 0);
    drive(0, 0, 4'b0000, 3'b000, 0, 0); step();

    // Timeout: error exactly 16 cycles after WAIT_START entry.
    drive(1, 0, 4'b0000, 3'b000, 0, 0); step();
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("timeout_c%0d", k), 0, 4'b0000, 2'b11, 0, (k == 16));
    end
    drive(0, 0, 4'b0000, 3'b000, 0, 0); step();
    chk("timeout_clear", 0, 4'b0000, 2'b11, 0, 0);

    // Asynchronous reset while sitting in DEGRADE_RESP.
    drive(1, 0, 4'b0000, 3'b000, 0, 0); step();
    drive(1, 1, 4'b0001, 3'b000, 0, 0); step();
    drive(1, 0, 4'b0000, 3'b000, 0, 0); step();
    drive(1, 0, 4'b0000, 3'b000, 0, 1); step();
    drive(1, 1, 4'b0101, 3'b001, 0, 0); step();
    drive(1, 0, 4'b0000, 3'b000, 0, 0); step();
    chk("rst_pre_pulse", 1, 4'b0110, 2'b01, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 0, 4'b0000, 2'b11, 0, 0);
    step();
    chk("rst_held", 0, 4'b0000, 2'b11, 0, 0);
    rst_n = 1'b1;
    drive(1, 0, 4'b0000, 3'b000, 0, 0); step();
    drive(1, 1, 4'b0001, 3'b000, 0, 0); step();
    drive(1, 0, 4'b0000, 3'b000, 0, 0); step();
    chk("rst_restart_pulse", 1, 4'b0010, 2'b11, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
